// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/flush control slice.
// Used by hazard_flush_ctrl and load_use_detect.
package hazard_pkg;

    localparam int REG_IDX_W_DEF = 2;
    localparam int PERF_CNT_W    = 16;

    typedef enum logic [1:0] {
        RESET_HOLD,
        RUN,
        BR_FLUSH,
        MEM_WAIT
    } hz_state_e;

    // Saturating increment shared by the performance counters.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a decode-stage source matches the
// destination of a load still sitting in EX. Also intended for the forwarding unit.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic                 ex_reg_write,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 lu
);

    assign lu = ex_mem_read & ex_reg_write &
                ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline front-end control: load-use bubbles, multi-cycle branch flush, memory-busy freeze.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int BR_PENALTY = 2,
    parameter int REG_IDX_W  = REG_IDX_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_IDX_W-1:0]  id_rs,
    input  logic [REG_IDX_W-1:0]  id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_IDX_W-1:0]  ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  stall_active,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt
);

    localparam int                CNT_W      = $clog2(BR_PENALTY) + 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(BR_PENALTY - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             stall_q;
    logic             lu;

    load_use_detect #(.REG_IDX_W(REG_IDX_W)) u_lu (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .lu           (lu)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_HOLD;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            stall_q <= (state_d == BR_FLUSH) || (state_d == MEM_WAIT);
        end
    end

    // NOTE: every output and next-state term gets a default first, so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        unique case (state_q)
            RESET_HOLD: state_d = RUN;
            RUN: begin
                pc_write_en    = 1'b1;
                if_id_write_en = 1'b1;
                if_id_flush    = 1'b0;
                id_ex_flush    = 1'b0;
                if (ex_branch_taken || pend_q) begin
                    // A branch that arrived during a memory wait is serviced here too.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    pend_d      = 1'b0;
                    if (BR_PENALTY > 1) begin
                        state_d = BR_FLUSH;
                        cnt_d   = CNT_RELOAD;
                    end
                end else if (mem_busy) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    state_d        = MEM_WAIT;
                end else if (lu) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_flush    = 1'b1;
                end
            end
            BR_FLUSH: begin
                pc_write_en    = 1'b1;
                if_id_write_en = 1'b1;
                if (ex_branch_taken) begin
                    cnt_d = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if_id_flush = 1'b0;
                id_ex_flush = 1'b0;
                pend_d      = pend_q | ex_branch_taken;
                if (!mem_busy) state_d = RUN;
            end
            default: state_d = RESET_HOLD;
        endcase
    end

    assign stall_active = stall_q;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic                  branch_entry;

    assign branch_entry = ((state_q == RUN) && (ex_branch_taken || pend_q)) ||
                          ((state_q == BR_FLUSH) && ex_branch_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q != RESET_HOLD) && !pc_write_en) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (branch_entry) flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: BR_PENALTY=2 and BR_PENALTY=1 instances share stimulus;
// directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write, ex_branch_taken, mem_busy;

    logic        pc_we2, ifid_we2, iff2, idf2, sa2;
    logic        pc_we1, ifid_we1, iff1, idf1, sa1;
    logic [15:0] ps2, pf2, ps1, pf1;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = BR_PENALTY 2, index 1 = BR_PENALTY 1.
    int  pen [2] = '{2, 1};
    bit  m_hold [2];
    bit  m_wait [2];
    bit  m_pend [2];
    int  m_left [2];
    int  m_stall [2];
    int  m_flush [2];

    // Output vectors are {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, stall_active}.
    logic [4:0]  obs_v [2];
    logic [4:0]  exp_v [2];
    logic [15:0] obs_ps [2];
    logic [15:0] obs_pf [2];
    logic [15:0] exp_ps [2];
    logic [15:0] exp_pf [2];

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.BR_PENALTY(2), .REG_IDX_W(2)) u_p2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write_en(pc_we2), .if_id_write_en(ifid_we2),
        .if_id_flush(iff2), .id_ex_flush(idf2), .stall_active(sa2),
        .perf_stall_cnt(ps2), .perf_flush_cnt(pf2)
    );

    hazard_flush_ctrl #(.BR_PENALTY(1), .REG_IDX_W(2)) u_p1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write_en(pc_we1), .if_id_write_en(ifid_we1),
        .if_id_flush(iff1), .id_ex_flush(idf1), .stall_active(sa1),
        .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
    );

    function automatic int sat16(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // Canonical load-use pattern: load to r2 in EX, decode reads r2 through rs.
    task automatic set_lu(input bit on);
        ex_mem_read  = on;
        ex_reg_write = 1'b1;
        ex_rd        = 2'd2;
        id_uses_rs   = 1'b1;
        id_rs        = 2'd2;
        id_uses_rt   = 1'b0;
        id_rt        = 2'd0;
    endtask

    // Inputs are already applied (posedge + 1). Sample at the falling edge, advance the
    // model by one cycle, then move to just after the next rising edge.
    task automatic step();
        bit lu_m;
        #4;
        obs_v[0]  = {pc_we2, ifid_we2, iff2, idf2, sa2};
        obs_v[1]  = {pc_we1, ifid_we1, iff1, idf1, sa1};
        obs_ps[0] = ps2;  obs_pf[0] = pf2;
        obs_ps[1] = ps1;  obs_pf[1] = pf1;
        lu_m = ex_mem_read && ex_reg_write &&
               ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
        for (int k = 0; k < 2; k++) begin
            exp_ps[k] = rst ? 16'h0 : 16'(m_stall[k]);
            exp_pf[k] = rst ? 16'h0 : 16'(m_flush[k]);
`ifndef HAZ_PERF_CNT_EN
            exp_ps[k] = 16'h0;
            exp_pf[k] = 16'h0;
`endif
            if (rst) begin
                exp_v[k] = 5'b00110;
                m_hold[k] = 1'b1; m_wait[k] = 1'b0; m_pend[k] = 1'b0;
                m_left[k] = 0;    m_stall[k] = 0;   m_flush[k] = 0;
            end else if (m_hold[k]) begin
                exp_v[k]  = 5'b00110;
                m_hold[k] = 1'b0;
            end else if (m_left[k] > 0) begin
                exp_v[k] = 5'b11111;
                if (ex_branch_taken) begin
                    m_left[k]  = pen[k] - 1;
                    m_flush[k] = sat16(m_flush[k]);
                end else begin
                    m_left[k] = m_left[k] - 1;
                end
            end else if (m_wait[k]) begin
                exp_v[k]   = 5'b00001;
                m_stall[k] = sat16(m_stall[k]);
                m_pend[k]  = m_pend[k] | ex_branch_taken;
                if (!mem_busy) m_wait[k] = 1'b0;
            end else if (ex_branch_taken || m_pend[k]) begin
                exp_v[k]   = 5'b11110;
                m_flush[k] = sat16(m_flush[k]);
                m_pend[k]  = 1'b0;
                m_left[k]  = pen[k] - 1;
            end else if (mem_busy) begin
                exp_v[k]   = 5'b00000;
                m_stall[k] = sat16(m_stall[k]);
                m_wait[k]  = 1'b1;
            end else if (lu_m) begin
                exp_v[k]   = 5'b00010;
                m_stall[k] = sat16(m_stall[k]);
            end else begin
                exp_v[k] = 5'b11000;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        set_lu(1'b0);
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1; step();
        rst = 1'b0; step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_v[0] !== 5'b00110 || obs_v[1] !== 5'b00110) begin
                errors++;
                $display("FAIL reset_active cyc%0d: p2=%b p1=%b required 00110", i, obs_v[0], obs_v[1]);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs_v[0] !== 5'b00110 || obs_v[1] !== 5'b00110) begin
            errors++;
            $display("FAIL reset_hold: p2=%b p1=%b required 00110", obs_v[0], obs_v[1]);
        end
        step();
        checks++;
        if (obs_v[0] !== 5'b11000 || obs_v[1] !== 5'b11000) begin
            errors++;
            $display("FAIL reset_to_run: p2=%b p1=%b required 11000", obs_v[0], obs_v[1]);
        end
    endtask

    task automatic test_load_use();
        logic [4:0] want [6] = '{5'b00010, 5'b11000, 5'b11000, 5'b00010, 5'b11000, 5'b11000};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            set_lu(1'b1);
            case (i)
                1: ex_mem_read = 1'b0;                                  // bubble cleared the load
                2: id_uses_rs = 1'b0;                                   // index matches but rs unused
                3: begin id_uses_rs = 1'b0; id_uses_rt = 1'b1; id_rt = 2'd2; end
                4: begin id_uses_rt = 1'b1; id_rt = 2'd2; ex_reg_write = 1'b0; end
                5: id_rs = 2'd3;                                        // full-width mismatch
                default: ;
            endcase
            step();
            checks++;
            if (obs_v[0] !== want[i] || obs_v[1] !== want[i]) begin
                errors++;
                $display("FAIL load_use cyc%0d: p2=%b p1=%b required %b", i, obs_v[0], obs_v[1], want[i]);
            end
        end
        idle();
    endtask

    // Stimulus per cycle is {rst, ex_branch_taken, mem_busy, load_use}.
    task automatic test_branch();
        logic [3:0] stim [11] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
                                  4'b0000, 4'b0111, 4'b0011, 4'b0000, 4'b0000};
        logic [4:0] w2 [11] = '{5'b11110, 5'b11111, 5'b11000, 5'b11110, 5'b11111, 5'b11111,
                                5'b11000, 5'b11110, 5'b11111, 5'b11000, 5'b11000};
        logic [4:0] w1 [11] = '{5'b11110, 5'b11000, 5'b11000, 5'b11110, 5'b11110, 5'b11000,
                                5'b11000, 5'b11110, 5'b00000, 5'b00001, 5'b11000};
        bit lu_on;
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            {rst, ex_branch_taken, mem_busy, lu_on} = stim[i];
            set_lu(lu_on);
            step();
            checks++;
            if (obs_v[0] !== w2[i] || obs_v[1] !== w1[i]) begin
                errors++;
                $display("FAIL branch cyc%0d: p2=%b p1=%b required p2=%b p1=%b",
                         i, obs_v[0], obs_v[1], w2[i], w1[i]);
            end
        end
        idle();
    endtask

    task automatic test_mem_wait();
        logic [3:0] stim [7] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
        logic [4:0] want [7] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00010, 5'b11000};
        bit lu_on;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            {rst, ex_branch_taken, mem_busy, lu_on} = stim[i];
            set_lu(lu_on);
            step();
            checks++;
            if (obs_v[0] !== want[i] || obs_v[1] !== want[i]) begin
                errors++;
                $display("FAIL mem_wait cyc%0d: p2=%b p1=%b required %b", i, obs_v[0], obs_v[1], want[i]);
            end
        end
        idle();
    endtask

    task automatic test_branch_during_wait();
        logic [3:0] stim [8] = '{4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        logic [4:0] w2 [8] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b11110, 5'b11111, 5'b11000, 5'b00010};
        logic [4:0] w1 [8] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b11110, 5'b11000, 5'b11000, 5'b00010};
        bit lu_on;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            {rst, ex_branch_taken, mem_busy, lu_on} = stim[i];
            set_lu(lu_on);
            step();
            checks++;
            if (obs_v[0] !== w2[i] || obs_v[1] !== w1[i]) begin
                errors++;
                $display("FAIL branch_in_wait cyc%0d: p2=%b p1=%b required p2=%b p1=%b",
                         i, obs_v[0], obs_v[1], w2[i], w1[i]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [3:0] stim [9] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0010,
                                 4'b0110, 4'b1010, 4'b0000, 4'b0000};
        logic [4:0] w2 [9] = '{5'b11110, 5'b00110, 5'b00110, 5'b11000, 5'b00000,
                               5'b00001, 5'b00110, 5'b00110, 5'b11000};
        bit lu_on;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            {rst, ex_branch_taken, mem_busy, lu_on} = stim[i];
            set_lu(lu_on);
            step();
            checks++;
            if (obs_v[0] !== w2[i] || obs_v[1] !== exp_v[1]) begin
                errors++;
                $display("FAIL reset_mid cyc%0d: p2=%b p1=%b required p2=%b p1=%b",
                         i, obs_v[0], obs_v[1], w2[i], exp_v[1]);
            end
        end
        idle();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 299) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_busy        = ($urandom_range(0, 5) == 0) || (mem_busy && ($urandom_range(0, 2) != 0));
            ex_mem_read     = $urandom_range(0, 1);
            ex_reg_write    = ($urandom_range(0, 3) != 0);
            id_uses_rs      = $urandom_range(0, 1);
            id_uses_rt      = $urandom_range(0, 1);
            id_rs           = 2'($urandom_range(0, 3));
            id_rt           = 2'($urandom_range(0, 3));
            ex_rd           = 2'($urandom_range(0, 3));
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL random_ctrl inst%0d cyc%0d: got %b required %b", k, i, obs_v[k], exp_v[k]);
                end
                checks++;
                if (obs_ps[k] !== exp_ps[k] || obs_pf[k] !== exp_pf[k]) begin
                    errors++;
                    $display("FAIL random_perf inst%0d cyc%0d: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                             k, i, obs_ps[k], obs_pf[k], exp_ps[k], exp_pf[k]);
                end
            end
        end
        idle();
    endtask

    task automatic test_perf();
        logic [3:0]  stim [5] = '{4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic [15:0] want_cnt;
        int          busy_len;
        bit          lu_on;
`ifdef HAZ_PERF_CNT_EN
        want_cnt = 16'd1;
        busy_len = 65600;
`else
        want_cnt = 16'd0;
        busy_len = 100;
`endif
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            {rst, ex_branch_taken, mem_busy, lu_on} = stim[i];
            set_lu(lu_on);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_ps[k] !== want_cnt || obs_pf[k] !== want_cnt) begin
                errors++;
                $display("FAIL perf_branch_lu inst%0d: got stall=%0d flush=%0d required %0d each",
                         k, obs_ps[k], obs_pf[k], want_cnt);
            end
        end
        idle();
        mem_busy = 1'b1;
        for (int i = 0; i < busy_len; i++) step();
`ifdef HAZ_PERF_CNT_EN
        want_cnt = 16'hFFFF;
`endif
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_ps[k] !== want_cnt) begin
                    errors++;
                    $display("FAIL perf_saturate inst%0d sample%0d: got %h required %h", k, n, obs_ps[k], want_cnt);
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 1'b1; m_wait[k] = 1'b0; m_pend[k] = 1'b0;
            m_left[k] = 0;    m_stall[k] = 0;   m_flush[k] = 0;
        end
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_branch_during_wait();
        test_reset_mid();
        test_random();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
